// File: rtl/debounce4_pkg.sv
// Shared types and constants for the four-channel debouncer.
// Build option: DEBOUNCE4_SYNC_EN adds a two-flop input synchronizer.
package debounce4_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } ch_state_t;

   localparam int NUM_CH = 4;

   function automatic int cnt_width(input int cycles);
      int w;
      for (w = 1; (1 << w) < cycles; w++) begin
      end
      return w;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: optional synchronizer, hold counter, FSM, output flops.
// Build option: DEBOUNCE4_SYNC_EN inserts a two-flop synchronizer on din.
module debounce_ch
   import debounce4_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic chg,
   output logic idle
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   ch_state_t     state;
   logic [CW-1:0] cnt;
   logic          smp;

`ifdef DEBOUNCE4_SYNC_EN
   logic sync1;
   logic sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   assign smp = sync2;
`else
   assign smp = din;
`endif

   assign idle = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         dout  <= 1'b0;
         chg   <= 1'b0;
      end else begin
         chg <= 1'b0;
         unique case (state)
            IDLE: begin
               if (smp != dout) begin
                  state <= PEND;
                  cnt   <= CW'(1);
               end
            end
            PEND: begin
               if (smp == dout) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  // Level held long enough: commit it and flag the change.
                  dout  <= smp;
                  chg   <= 1'b1;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/debounce4.sv
// Four independent debounce channels plus a registered all-idle flag.
// Build option: DEBOUNCE4_SYNC_EN adds a two-flop synchronizer per input.
module debounce4
   import debounce4_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       I0,
   input  logic       I1,
   input  logic       I2,
   input  logic       I3,
   output logic       O0,
   output logic       O1,
   output logic       O2,
   output logic       O3,
   output logic [3:0] CHG,
   output logic       STABLE
);

   logic [NUM_CH-1:0] din;
   logic [NUM_CH-1:0] dout;
   logic [NUM_CH-1:0] idle;

   assign din = {I3, I2, I1, I0};
   assign {O3, O2, O1, O0} = dout;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk  (CLK),
         .rst  (RST),
         .din  (din[n]),
         .dout (dout[n]),
         .chg  (CHG[n]),
         .idle (idle[n])
      );
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         STABLE <= 1'b1;
      end else begin
         STABLE <= &idle;
      end
   end

endmodule

// File: tb/tb_debounce4.sv
// Directed, table-driven bench for debounce4 with DEBOUNCE_CYCLES=4.
module tb_debounce4;

   typedef struct {
      logic       rst;
      logic [3:0] i;
      logic [3:0] o;
      logic [3:0] chg;
      logic       st;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       I0 = 1'b0, I1 = 1'b0, I2 = 1'b0, I3 = 1'b0;
   logic       O0, O1, O2, O3;
   logic [3:0] CHG;
   logic       STABLE;

   int n_chk = 0;
   int n_err = 0;

   vec_t vq[$];

   always #5 CLK = ~CLK;

   debounce4 #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .I0     (I0),
      .I1     (I1),
      .I2     (I2),
      .I3     (I3),
      .O0     (O0),
      .O1     (O1),
      .O2     (O2),
      .O3     (O3),
      .CHG    (CHG),
      .STABLE (STABLE)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] i, input logic [3:0] o,
                      input logic [3:0] c, input logic s);
      vec_t v;
      v.rst = r; v.i = i; v.o = o; v.chg = c; v.st = s;
      vq.push_back(v);
   endtask

   task automatic drive(input logic r, input logic [3:0] i);
      RST = r;
      {I3, I2, I1, I0} = i;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [3:0] outs();
      return {O3, O2, O1, O0};
   endfunction

   initial begin
      int n;
      logic bad;

      repeat (3) add(1, 4'b1111, 4'b0000, 4'b0000, 1);
      add(0, 4'b0000, 4'b0000, 4'b0000, 1);
      // single channel qualifies after four edges
      add(0, 4'b0001, 4'b0000, 4'b0000, 1);
      add(0, 4'b0001, 4'b0000, 4'b0000, 0);
      add(0, 4'b0001, 4'b0000, 4'b0000, 0);
      add(0, 4'b0001, 4'b0001, 4'b0001, 0);
      add(0, 4'b0001, 4'b0001, 4'b0000, 1);
      // three-edge pulse on I1 is rejected
      add(0, 4'b0011, 4'b0001, 4'b0000, 1);
      add(0, 4'b0011, 4'b0001, 4'b0000, 0);
      add(0, 4'b0011, 4'b0001, 4'b0000, 0);
      add(0, 4'b0001, 4'b0001, 4'b0000, 0);
      add(0, 4'b0001, 4'b0001, 4'b0000, 1);
      // count restarted from zero: full four edges again
      add(0, 4'b0011, 4'b0001, 4'b0000, 1);
      add(0, 4'b0011, 4'b0001, 4'b0000, 0);
      add(0, 4'b0011, 4'b0001, 4'b0000, 0);
      add(0, 4'b0011, 4'b0011, 4'b0010, 0);
      add(0, 4'b0011, 4'b0011, 4'b0000, 1);
      // all four channels together
      add(1, 4'b0000, 4'b0000, 4'b0000, 1);
      add(0, 4'b1111, 4'b0000, 4'b0000, 1);
      add(0, 4'b1111, 4'b0000, 4'b0000, 0);
      add(0, 4'b1111, 4'b0000, 4'b0000, 0);
      add(0, 4'b1111, 4'b1111, 4'b1111, 0);
      add(0, 4'b1111, 4'b1111, 4'b0000, 1);
      // reset mid-pend discards progress on I2
      add(1, 4'b0000, 4'b0000, 4'b0000, 1);
      add(0, 4'b0100, 4'b0000, 4'b0000, 1);
      add(0, 4'b0100, 4'b0000, 4'b0000, 0);
      add(1, 4'b0100, 4'b0000, 4'b0000, 1);
      add(0, 4'b0100, 4'b0000, 4'b0000, 1);
      add(0, 4'b0100, 4'b0000, 4'b0000, 0);
      add(0, 4'b0100, 4'b0000, 4'b0000, 0);
      add(0, 4'b0100, 4'b0100, 4'b0100, 0);
      add(0, 4'b0100, 4'b0100, 4'b0000, 1);
      // falling edge also debounced
      add(0, 4'b0000, 4'b0100, 4'b0000, 1);
      add(0, 4'b0000, 4'b0100, 4'b0000, 0);
      add(0, 4'b0000, 4'b0100, 4'b0000, 0);
      add(0, 4'b0000, 4'b0000, 4'b0100, 0);
      add(0, 4'b0000, 4'b0000, 4'b0000, 1);

`ifdef DEBOUNCE4_SYNC_EN
      for (int k = 0; k < 3; k++) begin
         drive(1, 4'b1111);
         step();
         chk($sformatf("sync_rst%0d_o", k), outs(), 0);
         chk($sformatf("sync_rst%0d_chg", k), CHG, 0);
         chk($sformatf("sync_rst%0d_st", k), STABLE, 1);
      end
      drive(0, 4'b0000);
      repeat (3) step();
      drive(0, 4'b0001);
      n = 0;
      bad = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (O0) begin
            n = k;
            bad = 1'b0;
            break;
         end
      end
      chk("sync_lat_timeout", bad, 0);
      chk("sync_lat", n, 6);
      chk("sync_chg", CHG, 4'b0001);
      step();
      chk("sync_chg_off", CHG, 0);
      chk("sync_st", STABLE, 1);
`else
      foreach (vq[k]) begin
         drive(vq[k].rst, vq[k].i);
         step();
         chk($sformatf("v%0d_o", k), outs(), vq[k].o);
         chk($sformatf("v%0d_chg", k), CHG, vq[k].chg);
         chk($sformatf("v%0d_st", k), STABLE, vq[k].st);
      end

      // bounded wait for I3 to qualify from idle
      drive(0, 4'b1000);
      n = 0;
      bad = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (O3) begin
            n = k;
            bad = 1'b0;
            break;
         end
      end
      chk("i3_timeout", bad, 0);
      chk("i3_lat", n, 4);
      chk("i3_chg", CHG, 4'b1000);

      // long hold: no wrap, no spurious pulses
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (CHG != 0 || outs() != 4'b1000) bad = 1'b1;
      end
      chk("hold_quiet", bad, 0);
      chk("hold_st", STABLE, 1);

      // repeated three-edge dropouts never reach the output
      bad = 1'b0;
      for (int r = 0; r < 3; r++) begin
         drive(0, 4'b0000);
         repeat (3) begin
            step();
            if (CHG != 0 || outs() != 4'b1000) bad = 1'b1;
         end
         drive(0, 4'b1000);
         step();
         if (CHG != 0 || outs() != 4'b1000) bad = 1'b1;
      end
      chk("glitch_train", bad, 0);
      step();
      chk("glitch_st", STABLE, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/debounce4.md
DEBOUNCE4 -- requirements
Module: debounce4

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, consecutive clock edges a new input level must hold before the output follows (legal 2..65535).
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: I0, I1, I2, I3  input  1 each  raw channel inputs (switches or off-chip levels).
REQ-005 Port: O0, O1, O2, O3  output  1 each  debounced levels; these drive the I0..I3 inputs of the downstream 4-input AND gate.
REQ-006 Port: CHG  output  4  one-cycle pulse per channel (bit n = channel n) on the cycle On changes.
REQ-007 Port: STABLE  output  1  high when every channel is in state IDLE.

Function
REQ-008 Each channel SHALL be independent, with a counter of width ceil(log2(DEBOUNCE_CYCLES)) and a two-state FSM: IDLE (sampled input equals On) and PEND (sampled input differs from On).
REQ-009 IDLE -> PEND on an edge where the sampled input differs from On; the counter SHALL become 1.
REQ-010 In PEND, on an edge where the sampled input still differs and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-011 In PEND, on an edge where the sampled input differs and counter == DEBOUNCE_CYCLES-1, On SHALL take the input level, CHG[n] SHALL pulse high for exactly one cycle, the counter SHALL clear, and the state SHALL return to IDLE.
REQ-012 In PEND, on an edge where the sampled input equals On (glitch), the counter SHALL clear and the state SHALL return to IDLE; On and CHG[n] are unchanged.
REQ-013 Latency: an input level held for exactly DEBOUNCE_CYCLES consecutive sampling edges SHALL appear on On after the last of those edges; a level held for DEBOUNCE_CYCLES-1 edges SHALL not propagate.
REQ-014 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-015 Simultaneous qualification on several channels SHALL update all of them on the same edge, each with its own CHG bit.
REQ-016 STABLE SHALL be registered: high on the edge after all four FSMs are in IDLE, low on the edge after any FSM enters PEND.
REQ-017 Outputs O0..O3, CHG and STABLE SHALL be driven directly from flops; no combinational path from I0..I3 to any output.

Reset
REQ-018 While RST is high at a rising edge: O0..O3 = 0, CHG = 0, STABLE = 1, all counters = 0, all FSMs = IDLE.
REQ-019 Reset asserted mid-PEND SHALL discard the pending count; after release, a high input requires a full DEBOUNCE_CYCLES edges to propagate.
REQ-020 Synchronizer flops (when present) SHALL reset to 0.

Configuration
REQ-021 Macro DEBOUNCE4_SYNC_EN: when defined, each input SHALL pass through a two-flop synchronizer before the FSM, adding exactly 2 cycles of latency to REQ-013.
REQ-022 When DEBOUNCE4_SYNC_EN is undefined, the FSM SHALL sample I0..I3 directly; inputs are then required to be synchronous to CLK.

Structure
REQ-023 Shared package debounce4_pkg SHALL hold the FSM state encoding (IDLE=0, PEND=1), the channel count constant (4) and the counter-width function.
REQ-024 One sub-module debounce_ch (a single channel: optional synchronizer, counter, FSM, output flop, CHG pulse) SHALL be instantiated four times; debounce4 adds only the STABLE flop.

Verification (DEBOUNCE_CYCLES=4, DEBOUNCE4_SYNC_EN undefined unless stated)
REQ-025 Hold RST high 3 cycles with I0..I3 = 1 -> O0..O3 = 0, CHG = 0, STABLE = 1 throughout.
REQ-026 I0 rises and holds 4 edges -> O0 = 1 after the 4th edge, CHG = 4'b0001 for that one cycle, STABLE low for the edges in PEND, then high.
REQ-027 I1 high for 3 edges then low -> O1 stays 0, CHG[1] never pulses, counter back to 0.
REQ-028 I0..I3 rise on the same edge and hold -> all outputs rise on the same edge, CHG = 4'b1111 for one cycle.
REQ-029 I2 high 2 edges, RST pulse 1 cycle, I2 held high -> O2 rises 4 edges after RST deasserts, not earlier.
REQ-030 With DEBOUNCE4_SYNC_EN defined, repeat REQ-026 -> O0 rises 6 edges after I0 rises.
